// File: rtl/vga_pkg.sv
// Shared VGA timing types and defaults (640x480@60) for the timing generator.
package vga_pkg;

  typedef struct packed {
    logic [9:0] h_active;
    logic [9:0] h_fp;
    logic [9:0] h_sync;
    logic [9:0] h_bp;
    logic [9:0] v_active;
    logic [9:0] v_fp;
    logic [9:0] v_sync;
    logic [9:0] v_bp;
  } timing_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam timing_t VGA_640X480 = '{
    h_active: 10'(VGA_H_ACTIVE), h_fp: 10'(VGA_H_FP),
    h_sync:   10'(VGA_H_SYNC),   h_bp: 10'(VGA_H_BP),
    v_active: 10'(VGA_V_ACTIVE), v_fp: 10'(VGA_V_FP),
    v_sync:   10'(VGA_V_SYNC),   v_bp: 10'(VGA_V_BP)
  };

  function automatic int addr_width(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register that delays the packed {hs, vs, blank} triple by DEPTH pixel ticks.
module sync_delay_line #(
  parameter int         DEPTH     = 1,
  parameter logic [2:0] RESET_VAL = 3'b110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] pipe_p0 [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_p0[i] <= RESET_VAL;
    end else if (en) begin
      pipe_p0[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe_p0[i] <= pipe_p0[i-1];
    end
  end

  assign q = pipe_p0[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel enable, counters, delayed sync/blank, linear address.
// Optional frame_count output is enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DEPTH = 1,
  parameter bit SYNC_POL   = 1'b0,
  localparam int ADDR_W    = addr_width(H_ACTIVE, V_ACTIVE)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic              pixel_clk,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              line_start,
  output logic              frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]       frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [2:0] INACTIVE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV must be >= 1 and PIPE_DEPTH in 0..7");
  end

  function automatic logic [2:0] decode(input logic [9:0] x, input logic [9:0] y);
    logic h_on;
    logic v_on;
    h_on = (x >= HS_BEG) && (x <= HS_END);
    v_on = (y >= VS_BEG) && (y <= VS_END);
    return {h_on ? SYNC_POL : ~SYNC_POL, v_on ? SYNC_POL : ~SYNC_POL,
            (x < H_VIS) && (y < V_VIS)};
  endfunction

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             x_wrap;
  logic             y_wrap;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             vis;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_out;

  // Pixel-enable divider: pixel_clk is registered so it tracks div after reset
  assign div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div       <= '0;
      pixel_clk <= 1'b0;
    end else begin
      div       <= div_next;
      pixel_clk <= (div_next == DIV_LAST);
    end
  end

  always_comb begin
    x_wrap = (DrawX == H_LAST);
    y_wrap = (DrawY == V_LAST);
    x_next = x_wrap ? '0 : DrawX + 10'd1;
    y_next = DrawY;
    if (x_wrap) y_next = y_wrap ? '0 : DrawY + 10'd1;
    vis = (DrawX < H_VIS) && (DrawY < V_VIS);
  end

  // Stage p0: counters, address, strobes and sync decode of the new position
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      pixel_addr  <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_p0     <= INACTIVE;
    end else begin
      line_start  <= pixel_clk && x_wrap;
      frame_start <= pixel_clk && x_wrap && y_wrap;
      if (pixel_clk) begin
        DrawX   <= x_next;
        DrawY   <= y_next;
        sync_p0 <= decode(x_next, y_next);
        if (x_wrap && y_wrap) pixel_addr <= '0;
        else if (vis)         pixel_addr <= pixel_addr + ADDR_W'(1);
      end
    end
  end

  // Stage p1..pN: extra pixel-tick delay to match RAM readout latency
  if (PIPE_DEPTH == 0) begin : g_no_delay
    assign sync_out = sync_p0;
  end else begin : g_delay
    sync_delay_line #(
      .DEPTH     (PIPE_DEPTH),
      .RESET_VAL (INACTIVE)
    ) u_sync_delay_line (
      .clk   (Clk),
      .rst_n (Reset_n),
      .en    (pixel_clk),
      .d     (sync_p0),
      .q     (sync_out)
    );
  end

  assign {hs, vs, blank} = sync_out;

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_count <= '0;
    else if (pixel_clk && x_wrap && y_wrap) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 vga_controller.
- Generates pixel-enable, H/V counters, sync, blank and a linear framebuffer address from the 50 MHz system clock.
- Delays sync/blank by a configurable number of pixel ticks so they stay aligned with the latency of the frame/sprite RAM readout feeding color_mapper.
- Adds frame/line strobes so game logic does not need to clock off VGA_VS.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel (>=1)
PIPE_DEPTH, 1, pixel ticks of delay on hs/vs/blank (0..7)
SYNC_POL, 0, active level of hs and vs (0 = active-low)

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous active-low reset
pixel_clk  out  1  pixel enable; one Clk cycle high every CLK_DIV cycles
DrawX  out  10  horizontal counter, 0..H_TOTAL-1
DrawY  out  10  vertical counter, 0..V_TOTAL-1
pixel_addr  out  ADDR_W  DrawY*H_ACTIVE+DrawX inside the active area; ADDR_W = $clog2(H_ACTIVE*V_ACTIVE)
hs  out  1  horizontal sync, delayed PIPE_DEPTH ticks
vs  out  1  vertical sync, delayed PIPE_DEPTH ticks
blank  out  1  high = visible pixel (delayed PIPE_DEPTH ticks); 0 forces colour off
line_start  out  1  one-Clk pulse on the tick where DrawX wraps to 0
frame_start  out  1  one-Clk pulse on the tick where DrawX and DrawY both wrap to 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be <= 1024; an elaboration-time check fails otherwise.
- Reset (async assert, sync release): divider, DrawX, DrawY and pixel_addr = 0. pixel_clk, blank, line_start and frame_start = 0. hs and vs = inactive level (~SYNC_POL). Delay pipe is filled with the inactive pattern.
- Divider: counts 0..CLK_DIV-1. pixel_clk = (div == CLK_DIV-1). With CLK_DIV = 1, pixel_clk is held at 1.
- Counters advance only on Clk edges where pixel_clk = 1:
  - DrawX increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, DrawY increments and wraps V_TOTAL-1 -> 0.
- Undelayed sync/blank, decoded from the registered counters:
  - hs_raw active for DrawX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw active for DrawY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - vis = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE).
- Delay pipe:
  - hs, vs and blank equal the raw values from PIPE_DEPTH pixel ticks earlier.
  - The pipe shifts only when pixel_clk = 1.
  - PIPE_DEPTH = 0 gives registered outputs, same cycle as the counters.
- pixel_addr:
  - Computed incrementally, no multiplier.
  - Increments by 1 on each tick that leaves a visible pixel.
  - Cleared to 0 on the tick where the counters wrap to (0,0).
  - Outside the active area it holds the last value (the next line continues from it).
  - Whenever vis = 1 it must equal DrawY*H_ACTIVE+DrawX.
- line_start and frame_start:
  - Registered; high for exactly one Clk cycle, coincident with the counter update.
  - Both are high together at frame wrap.
- Reset mid-line: everything returns to reset values immediately. The first frame after release begins at (0,0) with frame_start asserted on the first wrap only; no pulse is issued on reset release.
- Counter widths are fixed at 10 bits; the upper bits are zero when the totals are smaller.

Optional Feature:
VGA_FRAME_COUNT_EN
- Defined: adds output frame_count [15:0].
  - Reset value 0.
  - Increments on every frame_start and wraps 65535 -> 0.
  - Used by level timers and blink effects.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package vga_pkg:
  - localparams for the 640x480@60 timing values.
  - a typedef struct for timing (h_active, h_fp, h_sync, h_bp and the V equivalents).
  - function addr_width(h, v).
- Sub-module sync_delay_line: PIPE_DEPTH-deep, 3-bit-wide shift register with an enable, used for hs/vs/blank.

Test Plan:
- Defaults, release reset, run 1 frame → 840000 Clk cycles between frame_start pulses; hs active-low for DrawX 656..751; vs low for DrawY 490..491.
- Defaults, sample at DrawX = 639, DrawY = 479 → pixel_addr = 307199. At the next frame_start, pixel_addr = 0. At (0,1), pixel_addr = 640.
- PIPE_DEPTH = 3 → blank rises 3 pixel ticks (6 Clk) after DrawX = 0 on line 0; hs falls 3 ticks after DrawX = 656.
- CLK_DIV = 1, H_ACTIVE = 8, H_FP = H_SYNC = H_BP = 2, V_ACTIVE = 4, V_FP = V_SYNC = V_BP = 1 → 14x7 = 98 cycles per frame; line_start every 14 cycles.
- Assert Reset_n low at DrawX = 300, DrawY = 100 → outputs reset immediately. After release: hs/vs inactive, first frame_start after 840000 cycles.
- With VGA_FRAME_COUNT_EN defined, run 3 frames → frame_count = 3.
